// File: rtl/ssd_mux_driver.sv
// ssd_mux_driver
//   Time-multiplexed driver for an N-digit common-anode 7-segment bank.
//   Scans one digit per slot, decodes hex nibbles, drives the decimal point,
//   honours per-digit enables and optional leading-zero blanking. It also
//   dims the display by PWM and keeps all segments off for a short guard at
//   the start of each slot, so the previous digit's pattern never bleeds
//   into the next anode. New data is double-buffered: it is written to
//   staging registers and moves to the active set only at a frame boundary,
//   so a scan never shows half-old, half-new data.
//
// Ports
//   clk         system clock
//   rst         asynchronous, active-high reset
//   digits_in   packed hex nibbles, digit i = digits_in[4i+3:4i], digit 0 rightmost
//   dp_in       decimal point per digit, 1 = lit
//   en_in       digit enable per digit, 1 = displayed
//   load        one-cycle strobe, captures digits_in/dp_in/en_in into staging
//   lz_blank    1 = blank leading zeros (level, sampled every cycle)
//   bright      PWM brightness, 0 = dark, all ones = always on
//   cc          cathodes {g,f,e,d,c,b,a}, active-low
//   dp_out      decimal-point cathode, active-low
//   an          anodes, active-low, at most one low at a time
//   frame_done  one-cycle pulse during the last cycle of each scan
//   pending     staging holds data not yet applied
//
// Handshake: load is a plain strobe with no back-pressure. Every cycle with
// load=1 overwrites staging; the last load before a frame boundary wins.
module ssd_mux_driver #(
    parameter int N_DIGITS        = 8,
    parameter int TICKS_PER_DIGIT = 100000,
    parameter int GUARD_TICKS     = 2,
    parameter int BRIGHT_W        = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*N_DIGITS-1:0] digits_in,
    input  logic [N_DIGITS-1:0]   dp_in,
    input  logic [N_DIGITS-1:0]   en_in,
    input  logic                  load,
    input  logic                  lz_blank,
    input  logic [BRIGHT_W-1:0]   bright,
    output logic [6:0]            cc,
    output logic                  dp_out,
    output logic [N_DIGITS-1:0]   an,
    output logic                  frame_done,
    output logic                  pending
);

    localparam int SLOT_W = (TICKS_PER_DIGIT > 1) ? $clog2(TICKS_PER_DIGIT) : 1;
    localparam int DIG_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(TICKS_PER_DIGIT - 1);
    localparam logic [SLOT_W-1:0] GUARD_END = SLOT_W'(GUARD_TICKS);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(N_DIGITS - 1);

    // Scan state
    logic [SLOT_W-1:0]   slot_cnt;
    logic [DIG_W-1:0]    digit_idx;
    logic [BRIGHT_W-1:0] pwm_cnt;

    // Double-buffered display data
    logic [4*N_DIGITS-1:0] stg_digits;
    logic [N_DIGITS-1:0]   stg_dp;
    logic [N_DIGITS-1:0]   stg_en;
    logic [4*N_DIGITS-1:0] act_digits;
    logic [N_DIGITS-1:0]   act_dp;
    logic [N_DIGITS-1:0]   act_en;

    // Next-state / selection signals
    logic                slot_wrap;
    logic                boundary;
    logic [SLOT_W-1:0]   slot_nxt;
    logic [DIG_W-1:0]    digit_nxt;
    logic                boundary_nxt;
    logic [N_DIGITS-1:0] blank_vec;
    logic                blank_run;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic                cur_en;
    logic                cur_blank;
    logic [N_DIGITS-1:0] an_sel;
    logic                pwm_on;
    logic                lit;

    function automatic logic [6:0] hex_decode(input logic [3:0] v);
        logic [6:0] seg;
        case (v)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Counter advance and frame boundary detection
    always_comb begin
        slot_wrap = (slot_cnt == SLOT_LAST);
        boundary  = slot_wrap && (digit_idx == DIG_LAST);
        slot_nxt  = slot_wrap ? '0 : slot_cnt + 1'b1;
        if (!slot_wrap) begin
            digit_nxt = digit_idx;
        end else if (digit_idx == DIG_LAST) begin
            digit_nxt = '0;
        end else begin
            digit_nxt = digit_idx + 1'b1;
        end
        // frame_done is registered from the next counter state so that it
        // is high exactly while the counters sit on the boundary cycle.
        boundary_nxt = (slot_nxt == SLOT_LAST) && (digit_nxt == DIG_LAST);
    end

    // Leading-zero blanking: walk from the most significant digit down;
    // the run of blanking stops at the first nonzero nibble. Digit 0 is
    // never blanked so an all-zero value still shows a single 0.
    always_comb begin
        blank_vec = '0;
        blank_run = lz_blank;
        for (int i = N_DIGITS - 1; i >= 1; i--) begin
            if (act_digits[4*i +: 4] != 4'h0) begin
                blank_run = 1'b0;
            end
            blank_vec[i] = blank_run;
        end
    end

    // Select the currently scanned digit
    always_comb begin
        cur_nib   = 4'h0;
        cur_dp    = 1'b0;
        cur_en    = 1'b0;
        cur_blank = 1'b0;
        an_sel    = '1;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (digit_idx == DIG_W'(i)) begin
                cur_nib   = act_digits[4*i +: 4];
                cur_dp    = act_dp[i];
                cur_en    = act_en[i];
                cur_blank = blank_vec[i];
                an_sel[i] = 1'b0;
            end
        end
        pwm_on = (bright == '1) || (pwm_cnt < bright);
        lit    = cur_en && (slot_cnt >= GUARD_END) && pwm_on;
    end

    // Scan counters and frame pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_cnt   <= '0;
            digit_idx  <= '0;
            pwm_cnt    <= '0;
            frame_done <= 1'b0;
        end else begin
            slot_cnt   <= slot_nxt;
            digit_idx  <= digit_nxt;
            pwm_cnt    <= pwm_cnt + 1'b1;
            frame_done <= boundary_nxt;
        end
    end

    // Staging / active buffers. A load on the boundary cycle still lets the
    // previous staging contents transfer; the new data stays pending.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_digits <= '0;
            stg_dp     <= '0;
            stg_en     <= '0;
            act_digits <= '0;
            act_dp     <= '0;
            act_en     <= '0;
            pending    <= 1'b0;
        end else begin
            if (boundary && pending) begin
                act_digits <= stg_digits;
                act_dp     <= stg_dp;
                act_en     <= stg_en;
            end
            if (load) begin
                stg_digits <= digits_in;
                stg_dp     <= dp_in;
                stg_en     <= en_in;
                pending    <= 1'b1;
            end else if (boundary) begin
                pending    <= 1'b0;
            end
        end
    end

    // Registered pin drivers; everything off unless the digit is lit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            an     <= '1;
            cc     <= 7'h7F;
            dp_out <= 1'b1;
        end else if (lit) begin
            an     <= an_sel;
            cc     <= cur_blank ? 7'h7F : hex_decode(cur_nib);
            dp_out <= ~cur_dp;
        end else begin
            an     <= '1;
            cc     <= 7'h7F;
            dp_out <= 1'b1;
        end
    end

endmodule

// File: tb/tb_ssd_mux_driver.sv
module tb_ssd_mux_driver;

    logic        clk;
    logic        rst;
    logic [15:0] digits_in;
    logic [3:0]  dp_in;
    logic [3:0]  en_in;
    logic        load;
    logic        lz_blank;
    logic [3:0]  bright;
    logic [6:0]  cc;
    logic        dp_out;
    logic [3:0]  an;
    logic        frame_done;
    logic        pending;

    int chk_cnt  = 0;
    int pass_cnt = 0;
    int kcnt;    // clock edges since reset release = scan state index

    logic [6:0] dec_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    ssd_mux_driver #(
        .N_DIGITS(4), .TICKS_PER_DIGIT(8), .GUARD_TICKS(2), .BRIGHT_W(4)
    ) dut (
        .clk(clk), .rst(rst), .digits_in(digits_in), .dp_in(dp_in),
        .en_in(en_in), .load(load), .lz_blank(lz_blank), .bright(bright),
        .cc(cc), .dp_out(dp_out), .an(an), .frame_done(frame_done),
        .pending(pending)
    );

    // ---------------- clock / reset reference ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) kcnt <= 0;
        else     kcnt <= kcnt + 1;
    end

    // Expected {an, cc, dp_out} for scan state s (4 digits, 8 ticks, 2 guard)
    function automatic logic [11:0] model(int s, logic [15:0] dg, logic [3:0] dp,
                                          logic [3:0] en, logic lz, logic [3:0] br);
        int         slot;
        int         d;
        int         pwm;
        logic       lit;
        logic       blank;
        logic [3:0] a;
        logic [3:0] nib;
        slot  = s % 8;
        d     = (s / 8) % 4;
        pwm   = s % 16;
        lit   = en[d] && (slot >= 2) && ((br == 4'hF) || (pwm < int'(br)));
        blank = lz && (d != 0);
        for (int j = d; j < 4; j++) if (dg[4*j +: 4] != 4'h0) blank = 1'b0;
        nib = dg[4*d +: 4];
        if (!lit) return {4'hF, 7'h7F, 1'b1};
        a    = 4'hF;
        a[d] = 1'b0;
        return {a, blank ? 7'h7F : dec_tab[nib], ~dp[d]};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_phase(input int p);
        int n = 0;
        while ((kcnt % 32) != p && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            chk_cnt++;
            $display("FAIL wait_phase: phase %0d not reached, kcnt=%0d", p, kcnt);
        end
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        digits_in = d;
        dp_in     = dp;
        en_in     = en;
        load      = 1'b1;
        @(negedge clk);
        load      = 1'b0;
    endtask

    // Load mid-frame, return at phase 0 with the data active for the frame ahead
    task automatic apply(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        wait_phase(5);
        do_load(d, dp, en);
        wait_phase(0);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        #12;
        chk_cnt++;
        if ({an, cc, dp_out, frame_done, pending} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0})
            $display("FAIL reset_hold: got an=%h cc=%h dp=%b fd=%b pend=%b, want F 7f 1 0 0",
                     an, cc, dp_out, frame_done, pending);
        else pass_cnt++;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (64) begin
            @(negedge clk);
            chk_cnt++;
            if ({an, cc, dp_out, pending} !== {4'hF, 7'h7F, 1'b1, 1'b0})
                $display("FAIL reset_dark k=%0d: got an=%h cc=%h dp=%b pend=%b, want F 7f 1 0",
                         kcnt, an, cc, dp_out, pending);
            else pass_cnt++;
            chk_cnt++;
            if (frame_done !== ((kcnt % 32) == 31))
                $display("FAIL frame_done k=%0d: got %b want %b", kcnt, frame_done, (kcnt % 32) == 31);
            else pass_cnt++;
        end
    endtask

    task automatic test_load();
        logic [3:0] an_t [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [6:0] cc_t [4] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000};
        logic       dp_t [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [11:0] exp_v;
        int slot;
        int d;
        bright   = 4'hF;
        lz_blank = 1'b0;
        wait_phase(5);
        do_load(16'h3210, 4'b0100, 4'hF);
        while ((kcnt % 32) != 0) begin
            chk_cnt++;
            if (pending !== 1'b1 || an !== 4'hF)
                $display("FAIL load_pending k=%0d: got pend=%b an=%h want 1 F", kcnt, pending, an);
            else pass_cnt++;
            @(negedge clk);
        end
        chk_cnt++;
        if (pending !== 1'b0) $display("FAIL load_applied: pending got %b want 0", pending);
        else pass_cnt++;
        repeat (32) begin
            @(negedge clk);
            slot  = (kcnt - 1) % 8;
            d     = ((kcnt - 1) / 8) % 4;
            exp_v = (slot < 2) ? {4'hF, 7'h7F, 1'b1} : {an_t[d], cc_t[d], dp_t[d]};
            chk_cnt++;
            if ({an, cc, dp_out} !== exp_v)
                $display("FAIL load_scan d=%0d slot=%0d: got %h/%b/%b want %h/%b/%b",
                         d, slot, an, cc, dp_out, exp_v[11:8], exp_v[7:1], exp_v[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_decode_sweep();
        for (int v = 0; v < 16; v++) begin
            apply(16'(v), 4'b0000, 4'b0001);
            wait_phase(5);   // state = digit 0, slot 4
            chk_cnt++;
            if ({an, cc} !== {4'hE, dec_tab[v]})
                $display("FAIL decode_%0h: got an=%h cc=%b want E %b", v, an, cc, dec_tab[v]);
            else pass_cnt++;
        end
    endtask

    task automatic test_lz_blank();
        logic [6:0] cc_a [4] = '{7'b1000000, 7'b0010010, 7'h7F, 7'h7F};
        logic [6:0] cc_b [4] = '{7'b1000000, 7'h7F, 7'h7F, 7'h7F};
        logic [3:0] an_t [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
        logic [11:0] exp_v;
        int slot;
        int d;
        lz_blank = 1'b1;
        apply(16'h0050, 4'b0000, 4'hF);
        repeat (32) begin
            @(negedge clk);
            slot  = (kcnt - 1) % 8;
            d     = ((kcnt - 1) / 8) % 4;
            exp_v = (slot < 2) ? {4'hF, 7'h7F, 1'b1} : {an_t[d], cc_a[d], 1'b1};
            chk_cnt++;
            if ({an, cc, dp_out} !== exp_v)
                $display("FAIL lz_0050 d=%0d slot=%0d: got %h/%b/%b want %h/%b/%b",
                         d, slot, an, cc, dp_out, exp_v[11:8], exp_v[7:1], exp_v[0]);
            else pass_cnt++;
        end
        // All zero with a dp on the blanked top digit: dp still shows
        apply(16'h0000, 4'b1000, 4'hF);
        repeat (32) begin
            @(negedge clk);
            slot  = (kcnt - 1) % 8;
            d     = ((kcnt - 1) / 8) % 4;
            exp_v = (slot < 2) ? {4'hF, 7'h7F, 1'b1} : {an_t[d], cc_b[d], d != 3};
            chk_cnt++;
            if ({an, cc, dp_out} !== exp_v)
                $display("FAIL lz_0000 d=%0d slot=%0d: got %h/%b/%b want %h/%b/%b",
                         d, slot, an, cc, dp_out, exp_v[11:8], exp_v[7:1], exp_v[0]);
            else pass_cnt++;
        end
        lz_blank = 1'b0;
    endtask

    task automatic test_pwm_enable();
        logic [11:0] exp_v;
        bright = 4'h0;
        apply(16'h3210, 4'b0100, 4'hF);
        repeat (32) begin
            @(negedge clk);
            chk_cnt++;
            if (an !== 4'hF) $display("FAIL bright0 k=%0d: an got %h want F", kcnt, an);
            else pass_cnt++;
        end
        bright = 4'h4;
        repeat (32) begin
            @(negedge clk);
            exp_v = model(kcnt - 1, 16'h3210, 4'b0100, 4'hF, 1'b0, 4'h4);
            chk_cnt++;
            if ({an, cc, dp_out} !== exp_v)
                $display("FAIL bright4 k=%0d: got %h/%b/%b want %h/%b/%b",
                         kcnt, an, cc, dp_out, exp_v[11:8], exp_v[7:1], exp_v[0]);
            else pass_cnt++;
        end
        bright = 4'hF;
        apply(16'h9876, 4'b1111, 4'b1011);
        repeat (32) begin
            @(negedge clk);
            exp_v = model(kcnt - 1, 16'h9876, 4'b1111, 4'b1011, 1'b0, 4'hF);
            chk_cnt++;
            if ({an, cc, dp_out} !== exp_v || an === 4'hB)
                $display("FAIL en1011 k=%0d: got %h/%b/%b want %h/%b/%b",
                         kcnt, an, cc, dp_out, exp_v[11:8], exp_v[7:1], exp_v[0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back();
        logic [11:0] exp_v;
        wait_phase(10);
        do_load(16'h1234, 4'b0001, 4'hF);
        wait_phase(31);
        do_load(16'h5678, 4'b1111, 4'hF);   // load on the boundary cycle
        chk_cnt++;
        if (pending !== 1'b1) $display("FAIL b2b_pending: got %b want 1", pending);
        else pass_cnt++;
        repeat (32) begin
            @(negedge clk);
            exp_v = model(kcnt - 1, 16'h1234, 4'b0001, 4'hF, 1'b0, 4'hF);
            chk_cnt++;
            if ({an, cc, dp_out} !== exp_v)
                $display("FAIL b2b_first k=%0d: got %h/%b/%b want %h/%b/%b",
                         kcnt, an, cc, dp_out, exp_v[11:8], exp_v[7:1], exp_v[0]);
            else pass_cnt++;
        end
        chk_cnt++;
        if (pending !== 1'b0) $display("FAIL b2b_drained: pending got %b want 0", pending);
        else pass_cnt++;
        repeat (20) begin
            @(negedge clk);
            exp_v = model(kcnt - 1, 16'h5678, 4'b1111, 4'hF, 1'b0, 4'hF);
            chk_cnt++;
            if ({an, cc, dp_out} !== exp_v)
                $display("FAIL b2b_second k=%0d: got %h/%b/%b want %h/%b/%b",
                         kcnt, an, cc, dp_out, exp_v[11:8], exp_v[7:1], exp_v[0]);
            else pass_cnt++;
        end
        // Mid-slot reset: outputs must go dark immediately (digit 2, slot 3 lit now)
        #2 rst = 1'b1;
        #1;
        chk_cnt++;
        if ({an, cc, dp_out, frame_done, pending} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0})
            $display("FAIL midrst: got an=%h cc=%h dp=%b fd=%b pend=%b, want F 7f 1 0 0",
                     an, cc, dp_out, frame_done, pending);
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
        repeat (32) begin
            @(negedge clk);
            chk_cnt++;
            if ({an, cc, frame_done} !== {4'hF, 7'h7F, (kcnt % 32) == 31})
                $display("FAIL post_rst k=%0d: got an=%h cc=%h fd=%b", kcnt, an, cc, frame_done);
            else pass_cnt++;
        end
        apply(16'hABCD, 4'b0010, 4'hF);
        repeat (32) begin
            @(negedge clk);
            exp_v = model(kcnt - 1, 16'hABCD, 4'b0010, 4'hF, 1'b0, 4'hF);
            chk_cnt++;
            if ({an, cc, dp_out} !== exp_v)
                $display("FAIL restart_scan k=%0d: got %h/%b/%b want %h/%b/%b",
                         kcnt, an, cc, dp_out, exp_v[11:8], exp_v[7:1], exp_v[0]);
            else pass_cnt++;
        end
    endtask

    initial begin
        rst       = 1'b1;
        digits_in = '0;
        dp_in     = '0;
        en_in     = '0;
        load      = 1'b0;
        lz_blank  = 1'b0;
        bright    = 4'hF;
        test_reset();
        test_load();
        test_decode_sweep();
        test_lz_blank();
        test_pwm_enable();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
